multicycle_controller: RTL and testbench

Main control unit for the multi-cycle RV32I core. It holds the instruction-sequencing FSM that steps the shared datapath (PC, IR, unified instruction/data memory, register file, single ALU) through fetch, decode, execute and writeback. It generates every write enable and mux select, decodes the ALU operation, and stalls on a memory-ready handshake. It sits inside the core top level, next to the datapath.

---
 rtl/riscv_ctrl_pkg.sv | 66 ++++++
 rtl/multicycle_controller_if.sv | 35 +++
 rtl/alu_decoder.sv | 30 +++
 rtl/multicycle_controller.sv | 135 +++++++++++++
 tb/tb_multicycle_controller.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: FSM states,
// opcodes, datapath select codes and the ALU operation class.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    // ALU operation class handed to the ALU decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src_of(input logic [6:0] opcode);
        case (opcode)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control-unit <-> datapath bundle: instruction fields and flags in,
// enables and mux selects out.
interface multicycle_controller_if;
    logic [6:0] i_Opcode;
    logic [2:0] i_Funct3;
    logic       i_Funct7b5;
    logic       i_Zero;
    logic       i_MemReady;
    logic       o_MemReq;
    logic       o_PCWrite;
    logic       o_AdrSrc;
    logic       o_MemWrite;
    logic       o_IRWrite;
    logic       o_RegWrite;
    logic [1:0] o_ResultSrc;
    logic [1:0] o_ALUSrcA;
    logic [1:0] o_ALUSrcB;
    logic [1:0] o_ImmSrc;
    logic [2:0] o_ALUControl;
    logic       o_Illegal;

    // controller side
    modport master (
        input  i_Opcode, i_Funct3, i_Funct7b5, i_Zero, i_MemReady,
        output o_MemReq, o_PCWrite, o_AdrSrc, o_MemWrite, o_IRWrite, o_RegWrite,
        output o_ResultSrc, o_ALUSrcA, o_ALUSrcB, o_ImmSrc, o_ALUControl, o_Illegal
    );

    // datapath side
    modport slave (
        output i_Opcode, i_Funct3, i_Funct7b5, i_Zero, i_MemReady,
        input  o_MemReq, o_PCWrite, o_AdrSrc, o_MemWrite, o_IRWrite, o_RegWrite,
        input  o_ResultSrc, o_ALUSrcA, o_ALUSrcB, o_ImmSrc, o_ALUControl, o_Illegal
    );
endinterface

// File: rtl/alu_decoder.sv
// Maps the ALU operation class plus instruction fields to the ALU function code.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // op5 separates R-type from I-ALU: addi never subtracts
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Instruction-sequencing FSM of the multi-cycle RV32I core: drives every
// datapath enable and select, stalling on the memory-ready handshake.
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic                    i_Clk,
    input  logic                    i_Reset,
    multicycle_controller_if.master bus
);

    state_t     state_reg, state_next;
    logic       illegal_reg;
    alu_op_t    alu_op;
    logic       mem_req, pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b;

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            state_reg   <= S_FETCH;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            illegal_reg <= illegal_reg | (state_next == S_TRAP);
        end
    end

    always_comb begin
        state_next = state_reg;
        mem_req    = 1'b0;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        case (state_reg)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = bus.i_MemReady;
                pc_write   = bus.i_MemReady;
                if (bus.i_MemReady) state_next = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (bus.i_Opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECUTER;
                    OP_IALU:      state_next = S_EXECUTEI;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_JAL:       state_next = S_JAL;
                    default:      state_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                state_next = (bus.i_Opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (bus.i_MemReady) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                // strobe held through the whole wait; memory samples it on ready
                mem_req   = 1'b1;
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (bus.i_MemReady) state_next = S_FETCH;
            end
            S_EXECUTER: begin
                alu_src_a  = SRCA_RS1;
                alu_op     = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                alu_op     = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a  = SRCA_RS1;
                alu_op     = ALUOP_SUB;
                pc_write   = bus.i_Zero;
                state_next = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                pc_write   = 1'b1;
                state_next = S_ALUWB;
            end
            S_TRAP:  state_next = S_TRAP;
            default: state_next = S_FETCH;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (bus.i_Funct3),
        .funct7b5    (bus.i_Funct7b5),
        .op5         (bus.i_Opcode[5]),
        .alu_control (bus.o_ALUControl)
    );

    // Enables are masked by reset so nothing is written while it is held
    assign bus.o_MemReq    = mem_req   & i_Reset;
    assign bus.o_PCWrite   = pc_write  & i_Reset;
    assign bus.o_MemWrite  = mem_write & i_Reset;
    assign bus.o_IRWrite   = ir_write  & i_Reset;
    assign bus.o_RegWrite  = reg_write & i_Reset;
    assign bus.o_AdrSrc    = adr_src;
    assign bus.o_ResultSrc = result_src;
    assign bus.o_ALUSrcA   = alu_src_a;
    assign bus.o_ALUSrcB   = alu_src_b;
    assign bus.o_ImmSrc    = imm_src_of(bus.i_Opcode);
    assign bus.o_Illegal   = illegal_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller: every cycle the full
// control word is compared against a hand-written expected word.
module tb_multicycle_controller;

    logic i_Clk = 1'b0;
    logic i_Reset;
    int   n_vec = 0;
    int   n_err = 0;

    multicycle_controller_if bus();

    multicycle_controller dut (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .bus     (bus)
    );

    always #5 i_Clk = ~i_Clk;

    // {MemReq,PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,SrcA,SrcB,ImmSrc,ALUControl,Illegal}
    logic [17:0] obs;
    assign obs = {bus.o_MemReq, bus.o_PCWrite, bus.o_AdrSrc, bus.o_MemWrite, bus.o_IRWrite,
                  bus.o_RegWrite, bus.o_ResultSrc, bus.o_ALUSrcA, bus.o_ALUSrcB, bus.o_ImmSrc,
                  bus.o_ALUControl, bus.o_Illegal};

    function automatic logic [17:0] cw(input logic mr, pw, as, mw, ir, rw,
                                       input logic [1:0] rs, sa, sb, is,
                                       input logic [2:0] ac, input logic il);
        return {mr, pw, as, mw, ir, rw, rs, sa, sb, is, ac, il};
    endfunction

    task automatic check_eq(input string tag, input logic [17:0] got, input logic [17:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Called at posedge+1: sample at the falling edge, then advance one cycle
    task automatic cyc(input string tag, input logic [17:0] exp);
        #4;
        check_eq(tag, obs, exp);
        @(posedge i_Clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        bus.i_Opcode   = op;
        bus.i_Funct3   = f3;
        bus.i_Funct7b5 = f7;
    endtask

    initial begin
        i_Reset        = 1'b0;
        bus.i_MemReady = 1'b1;
        bus.i_Zero     = 1'b0;
        set_instr(7'b0000011, 3'b010, 1'b0);

        // reset held: enables low, FETCH selects visible
        cyc("reset", cw(0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 3'b000, 0));
        i_Reset = 1'b1;

        // lw, no stalls: 5 cycles
        cyc("lw_fetch",   cw(1,1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00, 3'b000, 0));
        cyc("lw_decode",  cw(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00, 3'b000, 0));
        cyc("lw_memadr",  cw(0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00, 3'b000, 0));
        cyc("lw_memread", cw(1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0));
        cyc("lw_memwb",   cw(0,0,0,0,0,1, 2'b01,2'b00,2'b00,2'b00, 3'b000, 0));
        $display("tb: lw sequence done");

        // sw with three not-ready cycles in MEMWRITE
        set_instr(7'b0100011, 3'b010, 1'b0);
        cyc("sw_fetch",  cw(1,1,0,0,1,0, 2'b10,2'b00,2'b10,2'b01, 3'b000, 0));
        cyc("sw_decode", cw(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b01, 3'b000, 0));
        cyc("sw_memadr", cw(0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b01, 3'b000, 0));
        bus.i_MemReady = 1'b0;
        for (int i = 0; i < 3; i++)
            cyc("sw_wait", cw(1,0,1,1,0,0, 2'b00,2'b00,2'b00,2'b01, 3'b000, 0));
        bus.i_MemReady = 1'b1;
        cyc("sw_done", cw(1,0,1,1,0,0, 2'b00,2'b00,2'b00,2'b01, 3'b000, 0));
        $display("tb: sw sequence done");

        // beq taken, with one stalled fetch cycle first
        set_instr(7'b1100011, 3'b000, 1'b0);
        bus.i_Zero     = 1'b1;
        bus.i_MemReady = 1'b0;
        cyc("beq_fstall", cw(1,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b10, 3'b000, 0));
        bus.i_MemReady = 1'b1;
        cyc("beq_fetch",  cw(1,1,0,0,1,0, 2'b10,2'b00,2'b10,2'b10, 3'b000, 0));
        cyc("beq_decode", cw(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b10, 3'b000, 0));
        cyc("beq_taken",  cw(0,1,0,0,0,0, 2'b00,2'b10,2'b00,2'b10, 3'b001, 0));
        // beq not taken
        bus.i_Zero = 1'b0;
        cyc("beq2_fetch",  cw(1,1,0,0,1,0, 2'b10,2'b00,2'b10,2'b10, 3'b000, 0));
        cyc("beq2_decode", cw(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b10, 3'b000, 0));
        cyc("beq_ntaken",  cw(0,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10, 3'b001, 0));
        $display("tb: beq sequences done");

        // R-type funct decode: sub, and, slt, or, reserved funct3 -> add
        begin
            logic [2:0] f3_tab [5] = '{3'b000, 3'b111, 3'b010, 3'b110, 3'b001};
            logic [2:0] ac_tab [5] = '{3'b001, 3'b010, 3'b101, 3'b011, 3'b000};
            for (int i = 0; i < 5; i++) begin
                set_instr(7'b0110011, f3_tab[i], 1'b1);
                cyc("r_fetch",  cw(1,1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00, 3'b000, 0));
                cyc("r_decode", cw(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00, 3'b000, 0));
                cyc("r_exec",   cw(0,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b00, ac_tab[i], 0));
                cyc("r_aluwb",  cw(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0));
                $display("tb: R-type funct3=%b done", f3_tab[i]);
            end
        end

        // addi with Funct7b5 set must still add
        set_instr(7'b0010011, 3'b000, 1'b1);
        cyc("i_fetch",  cw(1,1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00, 3'b000, 0));
        cyc("i_decode", cw(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00, 3'b000, 0));
        cyc("i_exec",   cw(0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00, 3'b000, 0));
        cyc("i_aluwb",  cw(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0));
        $display("tb: I-ALU sequence done");

        // jal: 4 cycles
        set_instr(7'b1101111, 3'b000, 1'b0);
        cyc("jal_fetch",  cw(1,1,0,0,1,0, 2'b10,2'b00,2'b10,2'b11, 3'b000, 0));
        cyc("jal_decode", cw(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b11, 3'b000, 0));
        cyc("jal_jal",    cw(0,1,0,0,0,0, 2'b00,2'b01,2'b10,2'b11, 3'b000, 0));
        cyc("jal_aluwb",  cw(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b11, 3'b000, 0));
        $display("tb: jal sequence done");

        // lw aborted by reset in MEMREAD: no MEMWB writeback afterwards
        set_instr(7'b0000011, 3'b010, 1'b0);
        cyc("ab_fetch",  cw(1,1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00, 3'b000, 0));
        cyc("ab_decode", cw(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00, 3'b000, 0));
        cyc("ab_memadr", cw(0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00, 3'b000, 0));
        i_Reset = 1'b0;
        cyc("ab_reset",  cw(0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 3'b000, 0));
        i_Reset = 1'b1;
        cyc("ab_refetch", cw(1,1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00, 3'b000, 0));
        cyc("ab_decode2", cw(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00, 3'b000, 0));
        $display("tb: reset abort done");
        // finish that lw so the next fetch starts cleanly
        cyc("ab_memadr2", cw(0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00, 3'b000, 0));
        cyc("ab_memread", cw(1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0));
        cyc("ab_memwb",   cw(0,0,0,0,0,1, 2'b01,2'b00,2'b00,2'b00, 3'b000, 0));

        // illegal opcode: TRAP is sticky until reset
        set_instr(7'b1111111, 3'b000, 1'b0);
        cyc("trap_fetch",  cw(1,1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00, 3'b000, 0));
        cyc("trap_decode", cw(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00, 3'b000, 0));
        for (int i = 0; i < 20; i++) begin
            bus.i_MemReady = i[0];
            cyc("trap_hold", cw(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 1));
        end
        bus.i_MemReady = 1'b1;
        i_Reset = 1'b0;
        #1;
        check_eq("trap_async_clr", obs, cw(0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 3'b000, 0));
        cyc("trap_reset", cw(0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 3'b000, 0));
        i_Reset = 1'b1;
        set_instr(7'b0110011, 3'b000, 1'b0);
        cyc("post_fetch", cw(1,1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00, 3'b000, 0));
        $display("tb: trap sequence done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
